// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth derivation.
// Used by both the write-side and read-side pointer blocks.
package fifo_pkg;

    function automatic int unsigned depth_of(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    // Narrower pointers are zero-extended in and truncated out by the caller.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_gray.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Synchronous active-high reset clears every stage.
module sync_gray #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller for the async FIFO: Gray write pointer,
// full / almost-full flags, fill count and sticky overflow error.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wq_rptr;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] cnt_next;
    logic          wen;
    logic          full_next;

    sync_gray #(
        .WIDTH (PW),
        .STAGES(SYNC_STAGES)
    ) u_rptr_sync (
        .clk(wclk),
        .rst(wrst),
        .d  (rptr),
        .q  (wq_rptr)
    );

    assign rbin_s    = PW'(gray2bin(32'(wq_rptr)));
    assign wen       = winc & ~wfull;
    assign wbinnext  = wbin + PW'(wen);
    assign wgraynext = PW'(bin2gray(32'(wbinnext)));
    assign cnt_next  = wbinnext - rbin_s;

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_next = (wgraynext ==
        {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});

    assign waddr = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= full_next;
            walmost_full <= (cnt_next >= afull_thresh);
            wcount       <= cnt_next;
            wovf         <= (wovf & ~wovf_clr) | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: directed scenarios plus random traffic
// checked against a count-based model of the write-side FIFO view.
module tb_wptr_full_ctrl;

    localparam int AS    = 4;
    localparam int DEPTH = 16;
    localparam int SS    = 2;

    logic          wclk;
    logic          wrst;
    logic          winc;
    logic [AS:0]   rptr;
    logic [AS:0]   afull_thresh;
    logic          wovf_clr;
    logic [AS-1:0] waddr;
    logic [AS:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AS:0]   wcount;
    logic          wovf;

    wptr_full_ctrl #(.ADDRSIZE(AS), .SYNC_STAGES(SS)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .rptr        (rptr),
        .afull_thresh(afull_thresh),
        .wovf_clr    (wovf_clr),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wcount      (wcount),
        .wovf        (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [AS-1:0] waddr;
        logic [AS:0]   wptr;
        logic          wfull;
        logic          waf;
        logic [AS:0]   wcount;
        logic          wovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: total accepted writes since reset, reader position,
    // and the rptr samples still travelling through the synchroniser.
    int wr = 0;
    int rd = 0;
    bit full_m = 0;
    bit ovf_m = 0;
    int pipe[$];

    function automatic logic [AS:0] to_gray(input int x);
        logic [AS:0] b;
        b = AS'(0);
        b = (AS+1)'(x % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic model_edge(input bit inc, input bit clr, input bit rs,
                              input int thr, input int rd_now);
        exp_t e;
        int used;
        int cnt;
        if (rs) begin
            wr = 0;
            full_m = 0;
            ovf_m = 0;
            pipe.delete();
            for (int i = 0; i < SS; i++) pipe.push_back(0);
            cnt = 0;
            e.waf = 1'b0;
        end else begin
            ovf_m = (ovf_m & ~clr) | (inc & full_m);
            if (inc && !full_m) wr++;
            used = pipe.pop_front();
            pipe.push_back(rd_now % 32);
            cnt = (wr - used) & 31;
            full_m = (cnt == DEPTH);
            e.waf = (cnt >= thr);
        end
        e.waddr  = AS'(wr % DEPTH);
        e.wptr   = to_gray(wr);
        e.wfull  = full_m;
        e.wcount = (AS+1)'(cnt);
        e.wovf   = ovf_m;
        sb.push_back(e);
    endtask

    task automatic step(input bit inc, input bit clr, input bit rs,
                        input int thr);
        @(negedge wclk);
        winc = inc;
        wovf_clr = clr;
        wrst = rs;
        afull_thresh = (AS+1)'(thr);
        rptr = to_gray(rd);
        @(posedge wclk);
        model_edge(inc, clr, rs, thr, rd);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every edge the DUT presents a fresh output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("waddr", int'(waddr), int'(e.waddr));
                chk("wptr", int'(wptr), int'(e.wptr));
                chk("wfull", int'(wfull), int'(e.wfull));
                chk("walmost_full", int'(walmost_full), int'(e.waf));
                chk("wcount", int'(wcount), int'(e.wcount));
                chk("wovf", int'(wovf), int'(e.wovf));
            end
        end
    end

    initial begin
        int h1;
        int h2;
        int thr;
        bit rs;
        winc = 0;
        wovf_clr = 0;
        wrst = 1;
        rptr = '0;
        afull_thresh = '0;

        rd = 0;
        step(0, 0, 1, 17);
        step(0, 0, 1, 17);
        // Fill to full, threshold above depth keeps almost-full low.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 17);
        step(0, 0, 0, 17);
        // Overflow attempt, set-over-clear, then clear alone.
        step(1, 0, 0, 17);
        step(1, 1, 0, 17);
        step(0, 1, 0, 17);
        step(0, 0, 0, 17);
        // Reader frees four entries; visible three edges later.
        rd = 4;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 17);
        step(1, 0, 0, 17);
        step(0, 0, 0, 17);

        // Almost-full threshold at 12, then at zero.
        rd = 0;
        step(0, 0, 1, 12);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 12);
        step(1, 0, 0, 12);
        step(0, 0, 0, 12);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Pointer wrap with the reader trailing by two edges.
        rd = 0;
        step(0, 0, 1, 8);
        h1 = 0;
        h2 = 0;
        for (int i = 0; i < 40; i++) begin
            rd = h2;
            h2 = h1;
            step(1, 0, 0, 8);
            h1 = wr;
        end

        // Mid-stream reset with count 9 and overflow set.
        rd = 0;
        step(0, 0, 1, 17);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 17);
        step(1, 0, 0, 17);
        rd = 7;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 17);
        rd = 0;
        step(0, 0, 1, 17);
        step(1, 0, 0, 17);
        step(0, 0, 0, 17);

        // Random traffic.
        thr = 10;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) thr = int'($urandom_range(0, 20));
            rs = ($urandom_range(0, 99) == 0);
            if (rs) rd = 0;
            else if (rd < wr && $urandom_range(0, 2) == 0) rd++;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, rs, thr);
        end
        step(0, 0, 0, thr);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge wclk);
        @(posedge wclk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
